// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Optional feature macro: UART_PARITY_EN (adds a parity bit after the data bits).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Parity over one data byte: even = XOR of the bits, odd = its complement.
    function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] data,
                                        input logic even);
        return even ? (^data) : (~^data);
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte/strobe input, frame configuration and status bundle of the UART transmitter.
// The transmitter takes the slave modport; the register block (or bench) takes master.
interface uart_tx_serializer_if #(
    parameter int DIV_W = 16
);
    logic [7:0]       CHAR_IN;
    logic             CHAR_STROBE;
    logic             TX_ENABLE;
    logic [DIV_W-1:0] BAUD_DIV;
    logic             STOP2;
    logic             PEN;
    logic             EPS;
    logic             TXD;
    logic             BUSY;
    logic             FIFO_FULL;
    logic             FIFO_EMPTY;
    logic             OVERFLOW;

    modport master (
        output CHAR_IN, CHAR_STROBE, TX_ENABLE, BAUD_DIV, STOP2, PEN, EPS,
        input  TXD, BUSY, FIFO_FULL, FIFO_EMPTY, OVERFLOW
    );

    modport slave (
        input  CHAR_IN, CHAR_STROBE, TX_ENABLE, BAUD_DIV, STOP2, PEN, EPS,
        output TXD, BUSY, FIFO_FULL, FIFO_EMPTY, OVERFLOW
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the serializer: RAM-style storage with a registered read port,
// registered full/empty flags and a one-cycle overflow pulse for dropped writes.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_req,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic             full_reg;
    logic             empty_reg;
    logic             overflow_reg;
    logic             push;
    logic             pop;

    // Full is judged on the registered flag, so a write into a full FIFO is dropped
    // even when a read frees a slot in the same cycle.
    assign push = wr_req & ~full_reg;
    assign pop  = rd_en & ~empty_reg;

    // Occupancy after this cycle's push/pop; simultaneous push and pop cancel out.
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // Pointers, occupancy and status flags; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg    <= count_next;
            full_reg     <= (count_next == (AW+1)'(DEPTH));
            empty_reg    <= (count_next == '0);
            overflow_reg <= wr_req & full_reg;
        end
    end

    // Storage array with a registered read port; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= wr_data;
        if (pop)  rd_data_reg     <= mem[rd_ptr_reg];
    end

    assign rd_data  = rd_data_reg;
    assign full     = full_reg;
    assign empty    = empty_reg;
    assign overflow = overflow_reg;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: buffers strobed bytes and sends each as start, 8 data bits (LSB
// first), optional parity, and 1 or 2 stop bits, each bit lasting BAUD_DIV+1 clocks.
// Optional feature macro: UART_PARITY_EN (enables the PARITY state and PEN/EPS inputs).
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_BITS  = 8,
    parameter int DIV_W      = 16
) (
    input logic               CLOCK,
    input logic               RESETn,
    uart_tx_serializer_if.slave bus
);
    localparam int             IDX_W    = $clog2(UART_DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

    tx_state_t                 state_reg;
    tx_state_t                 state_next;
    logic [DIV_W-1:0]          baud_cnt_reg;
    logic [DIV_W-1:0]          div_reg;
    logic                      stop2_reg;
    logic                      stop_idx_reg;
    logic [IDX_W-1:0]          bit_idx_reg;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic [UART_DATA_BITS-1:0] fifo_rd_data;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_overflow;
    logic                      bit_end;
    logic                      start_ok;
    logic                      pop;
    logic                      load_shift;
    logic                      data_step;
    logic                      txd;

`ifdef UART_PARITY_EN
    logic                      par_en_reg;
    logic                      eps_reg;
    logic                      par_bit_reg;
`else
    logic                      unused_parity_inputs;
    assign unused_parity_inputs = bus.PEN ^ bus.EPS;
`endif

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk      (CLOCK),
        .rst_n    (RESETn),
        .wr_data  (bus.CHAR_IN),
        .wr_req   (bus.CHAR_STROBE),
        .rd_en    (pop),
        .rd_data  (fifo_rd_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .overflow (fifo_overflow)
    );

    assign bit_end  = (baud_cnt_reg == '0);
    assign start_ok = bus.TX_ENABLE & ~fifo_empty;

    // Next-state and control strobes: pop on frame start, load/shift the data byte.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        load_shift = 1'b0;
        data_step  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_ok) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    load_shift = 1'b1;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    data_step = 1'b1;
                    if (bit_idx_reg == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        state_next = par_en_reg ? PARITY : STOP;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (stop2_reg && !stop_idx_reg) begin
                        state_next = STOP;
                    end else if (start_ok) begin
                        // Back-to-back frame: no idle bit between stop and start.
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    // Frame datapath: per-frame configuration latch, bit-time counter, shift register.
    // The FIFO read data arrives one clock after the pop, so the byte is moved into the
    // shift register at the end of the start bit (always at least one clock later).
    always_ff @(posedge CLOCK or negedge RESETn) begin
        if (!RESETn) begin
            baud_cnt_reg <= '0;
            div_reg      <= '0;
            stop2_reg    <= 1'b0;
            stop_idx_reg <= 1'b0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
`ifdef UART_PARITY_EN
            par_en_reg   <= 1'b0;
            eps_reg      <= 1'b0;
            par_bit_reg  <= 1'b0;
`endif
        end else begin
            if (pop) begin
                div_reg      <= bus.BAUD_DIV;
                baud_cnt_reg <= bus.BAUD_DIV;
                stop2_reg    <= bus.STOP2;
`ifdef UART_PARITY_EN
                par_en_reg   <= bus.PEN;
                eps_reg      <= bus.EPS;
`endif
            end else if (state_reg != IDLE) begin
                baud_cnt_reg <= bit_end ? div_reg : (baud_cnt_reg - DIV_W'(1));
            end

            if (load_shift) begin
                shift_reg   <= fifo_rd_data;
                bit_idx_reg <= '0;
`ifdef UART_PARITY_EN
                par_bit_reg <= parity_bit(fifo_rd_data, eps_reg);
`endif
            end else if (data_step) begin
                shift_reg   <= shift_reg >> 1;
                bit_idx_reg <= bit_idx_reg + IDX_W'(1);
            end

            if (state_reg == STOP && bit_end) begin
                stop_idx_reg <= stop2_reg & ~stop_idx_reg;
            end
        end
    end

    // Line level decoded from the current state; idle/stop levels are high.
    always_comb begin
        txd = UART_IDLE_LEVEL;
        case (state_reg)
            START:   txd = 1'b0;
            DATA:    txd = shift_reg[0];
`ifdef UART_PARITY_EN
            PARITY:  txd = par_bit_reg;
`endif
            default: txd = UART_IDLE_LEVEL;
        endcase
    end

    assign bus.TXD        = txd;
    assign bus.BUSY       = (state_reg != IDLE) | ~fifo_empty;
    assign bus.FIFO_FULL  = fifo_full;
    assign bus.FIFO_EMPTY = fifo_empty;
    assign bus.OVERFLOW   = fifo_overflow;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: stimulus queues expected frames, a monitor
// decodes TXD and compares each frame sample-by-sample against a waveform built from
// the frame rules (start, LSB-first data, optional parity, stop bits).
module tb_uart_tx_serializer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0] data;
        int         div;
        bit         stop2;
        bit         pen;
        bit         eps;
    } frame_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    uart_tx_serializer_if #(.DIV_W(16)) bus ();

    uart_tx_serializer #(
        .FIFO_DEPTH (DEPTH),
        .DATA_BITS  (8),
        .DIV_W      (16)
    ) dut (
        .CLOCK  (clk),
        .RESETn (rst_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    frame_t     exp_q[$];
    logic [7:0] bq[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    int         busy_cnt = 0;
    int         ovf_cnt = 0;
    int         busy_base;
    int         busy_exp;
    int         cur_div;
    bit         cur_stop2, cur_pen, cur_eps;

    always @(negedge clk) begin
        if (bus.BUSY)     busy_cnt++;
        if (bus.OVERFLOW) ovf_cnt++;
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    function automatic bit has_parity(input frame_t f);
`ifdef UART_PARITY_EN
        return f.pen;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int frame_len(input frame_t f);
        int nbits;
        nbits = 1 + 8 + (has_parity(f) ? 1 : 0) + (f.stop2 ? 2 : 1);
        return nbits * (f.div + 1);
    endfunction

    function automatic frame_t mk_frame(input logic [7:0] b);
        frame_t f;
        f.data  = b;
        f.div   = cur_div;
        f.stop2 = cur_stop2;
        f.pen   = cur_pen;
        f.eps   = cur_eps;
        return f;
    endfunction

    task automatic set_cfg(input int div, input bit s2, input bit pen, input bit eps);
        cur_div = div; cur_stop2 = s2; cur_pen = pen; cur_eps = eps;
        bus.BAUD_DIV = 16'(div);
        bus.STOP2    = s2;
        bus.PEN      = pen;
        bus.EPS      = eps;
    endtask

    task automatic strobe(input logic [7:0] b, input bit accept);
        bus.CHAR_IN     = b;
        bus.CHAR_STROBE = 1'b1;
        if (accept) exp_q.push_back(mk_frame(b));
        @(posedge clk);
        #1;
    endtask

    task automatic end_strobe();
        bus.CHAR_STROBE = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.BUSY && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (bus.BUSY) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: BUSY still 1 after %0d cycles, required 0", limit);
        end
    endtask

    // Strobes every byte of bq on consecutive cycles (idle, enabled DUT assumed).
    task automatic start_burst();
        busy_base = busy_cnt;
        busy_exp  = 1;
        foreach (bq[i]) begin
            strobe(bq[i], 1'b1);
            busy_exp += frame_len(mk_frame(bq[i]));
        end
        end_strobe();
    endtask

    task automatic finish_burst(input string name);
        wait_idle(2000);
        check({name, "_busy_cycles"}, busy_cnt - busy_base, busy_exp);
        check({name, "_queue_drained"}, exp_q.size(), 0);
    endtask

    // Monitor: on each start bit, pop the expected frame and compare every TXD sample.
    initial begin : monitor
        frame_t cur;
        logic   lv[$];
        int     idx, errs, first_bad, fno;
        bit     in_frame, rogue;
        logic   p;
        in_frame = 0; rogue = 0; fno = 0; idx = 0; errs = 0; first_bad = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_frame = 0;
                rogue    = 0;
            end else begin
                if (rogue && bus.TXD === 1'b1) rogue = 0;
                if (!in_frame && !rogue && bus.TXD === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        rogue = 1;
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_frame: TXD got 0 (start bit), required idle 1");
                    end else begin
                        cur = exp_q.pop_front();
                        lv.delete();
                        repeat (cur.div + 1) lv.push_back(1'b0);
                        for (int b = 0; b < 8; b++)
                            repeat (cur.div + 1) lv.push_back(cur.data[b]);
                        if (has_parity(cur)) begin
                            p = cur.eps ? (^cur.data) : (~^cur.data);
                            repeat (cur.div + 1) lv.push_back(p);
                        end
                        repeat ((cur.stop2 ? 2 : 1) * (cur.div + 1)) lv.push_back(1'b1);
                        idx = 0; errs = 0; first_bad = -1; in_frame = 1;
                    end
                end
                if (in_frame) begin
                    if (bus.TXD !== lv[idx]) begin
                        errs++;
                        if (first_bad < 0) first_bad = idx;
                    end
                    idx++;
                    if (idx == lv.size()) begin
                        in_frame = 0;
                        fno++;
                        n_cmp++;
                        if (errs != 0) begin
                            n_fail++;
                            $display("FAIL frame_%0d byte %02h: got %0d bad TXD samples (first at %0d), required 0",
                                     fno, cur.data, errs, first_bad);
                        end else begin
                            $display("ok   frame_%0d byte %02h div %0d stop2 %0d pen %0d eps %0d: %0d samples",
                                     fno, cur.data, cur.div, cur.stop2, cur.pen, cur.eps, lv.size());
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int txd_low;
        int n;
        int ob;
        bus.CHAR_IN     = 8'h00;
        bus.CHAR_STROBE = 1'b0;
        bus.TX_ENABLE   = 1'b0;
        set_cfg(3, 0, 0, 0);

        // Asynchronous reset values, before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("reset_txd", bus.TXD, 1);
        check("reset_busy", bus.BUSY, 0);
        check("reset_full", bus.FIFO_FULL, 0);
        check("reset_empty", bus.FIFO_EMPTY, 1);
        check("reset_overflow", bus.OVERFLOW, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.TX_ENABLE = 1'b1;

        // A5 at 4 clocks per bit, with first-frame latency.
        set_cfg(3, 0, 0, 0);
        bq = '{8'hA5};
        busy_base = busy_cnt;
        busy_exp  = 1 + 40;
        strobe(8'hA5, 1'b1);
        end_strobe();
        @(negedge clk);
        check("latency_txd_after_write", bus.TXD, 1);
        @(negedge clk);
        check("latency_txd_after_pop", bus.TXD, 0);
        finish_burst("a5");

        // Three bytes back-to-back at 1 clock per bit.
        set_cfg(0, 0, 0, 0);
        bq = '{8'h01, 8'h02, 8'h03};
        start_burst();
        repeat (19) @(negedge clk);
        check("b2b_empty_before_third_pop", bus.FIFO_EMPTY, 0);
        @(negedge clk);
        check("b2b_empty_after_third_pop", bus.FIFO_EMPTY, 1);
        finish_burst("b2b");

        // Fill with transmitter disabled, overflow on the 5th byte, then drain.
        bus.TX_ENABLE = 1'b0;
        set_cfg(2, 0, 0, 0);
        ob = ovf_cnt;
        for (int i = 0; i < DEPTH; i++) strobe(8'h10 + 8'(i), 1'b1);
        end_strobe();
        @(negedge clk);
        check("ovf_full_after_4", bus.FIFO_FULL, 1);
        check("ovf_busy_while_disabled", bus.BUSY, 1);
        strobe(8'hEE, 1'b0);
        end_strobe();
        @(negedge clk);
        check("ovf_pulse_high", bus.OVERFLOW, 1);
        @(negedge clk);
        check("ovf_pulse_low", bus.OVERFLOW, 0);
        txd_low = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.TXD !== 1'b1) txd_low++;
        end
        check("ovf_no_frame_while_disabled", txd_low, 0);
        check("ovf_pulse_count", ovf_cnt - ob, 1);
        bus.TX_ENABLE = 1'b1;
        wait_idle(2000);
        check("ovf_four_frames_sent", exp_q.size(), 0);

        // Two stop bits, 2 clocks per bit.
        set_cfg(1, 1, 0, 0);
        bq = '{8'hFF, 8'h00};
        start_burst();
        finish_burst("stop2");

        // Parity frames (plain 8N1 when the parity build option is off).
        set_cfg(2, 0, 1, 1);
        bq = '{8'h07};
        start_burst();
        finish_burst("par_even");
        set_cfg(2, 0, 1, 0);
        bq = '{8'h07};
        start_burst();
        finish_burst("par_odd");

        // Randomised bursts.
        for (int it = 0; it < 20; it++) begin
            set_cfg($urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n = $urandom_range(1, 4);
            bq.delete();
            for (int k = 0; k < n; k++) bq.push_back(8'($urandom_range(0, 255)));
            start_burst();
            finish_burst($sformatf("rand%0d", it));
        end

        // Reset in the middle of the data bits with two bytes still queued.
        set_cfg(3, 0, 0, 0);
        bq = '{8'h55, 8'hAA, 8'h3C};
        start_burst();
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midframe_reset_txd", bus.TXD, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_busy", bus.BUSY, 0);
        check("post_reset_empty", bus.FIFO_EMPTY, 1);
        busy_base = busy_cnt;
        repeat (100) @(negedge clk);
        check("post_reset_no_frames", busy_cnt - busy_base, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
